// File: rtl/sme_pkg.sv
// Shared constants, state encoding and helpers for the string-matching engine feeder.
package sme_pkg;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_STR,
    ST_SEND_PAT,
    ST_WAIT,
    ST_RESULT
  } feeder_state_e;

  // A run needs a non-empty pattern that fits, and a string that fits (0 = reuse).
  function automatic logic lens_ok(logic [5:0] s, logic [3:0] p, int smax, int pmax);
    return (p != 4'd0) && (32'(p) <= 32'(pmax)) && (32'(s) <= 32'(smax));
  endfunction

endpackage

// File: rtl/sme_feeder_if.sv
// Host and engine signals of the feeder, grouped; slave = feeder side, master = host/engine side.
interface sme_feeder_if;
  logic       wr_en;
  logic       wr_sel;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       start;
  logic       busy;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;
  logic       res_valid;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_timeout;
  logic       res_ready;

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, str_len, pat_len, start,
    input  valid, match, match_index, res_ready,
    output busy, chardata, isstring, ispattern,
    output res_valid, res_match, res_index, res_timeout
  );

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, str_len, pat_len, start,
    output valid, match, match_index, res_ready,
    input  busy, chardata, isstring, ispattern,
    input  res_valid, res_match, res_index, res_timeout
  );
endinterface

// File: rtl/sme_char_buf.sv
// Character buffer: one write port, one combinational read port, no reset on contents.
module sme_char_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 5,
  parameter int RW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [RW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Out-of-range addresses are dropped rather than wrapped onto a valid slot.
  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < 32'(DEPTH))) mem_q[waddr_i[RW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sme_feeder.sv
// Feeder: streams a stored string and pattern to the matcher, then returns its result to the host.
module sme_feeder #(
  parameter int STR_MAX = sme_pkg::STR_MAX,
  parameter int PAT_MAX = sme_pkg::PAT_MAX,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         reset,
  sme_feeder_if.slave bus
);
  import sme_pkg::*;

  localparam int SRW = $clog2(STR_MAX);
  localparam int PRW = $clog2(PAT_MAX);

  feeder_state_e state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] slen_q, slen_d;
  logic [3:0] plen_q, plen_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       busy_q, busy_d;
  logic [7:0] chardata_q, chardata_d;
  logic       isstring_q, isstring_d;
  logic       ispattern_q, ispattern_d;
  logic       res_valid_q, res_valid_d;
  logic       res_match_q, res_match_d;
  logic [4:0] res_index_q, res_index_d;
  logic       res_timeout_q, res_timeout_d;

  logic [SRW-1:0] str_raddr;
  logic [PRW-1:0] pat_raddr;
  logic [7:0]     str_rd, pat_rd;

  // Outside its own send phase each buffer is read at 0, ready for that phase's first char.
  assign str_raddr = (state_q == ST_SEND_STR) ? idx_q[SRW-1:0] : '0;
  assign pat_raddr = (state_q == ST_SEND_PAT) ? idx_q[PRW-1:0] : '0;

  sme_char_buf #(.DEPTH(STR_MAX), .AW(5)) u_str_buf (
    .clk     (clk),
    .we_i    (bus.wr_en && !busy_q && !bus.wr_sel),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (str_raddr),
    .rdata_o (str_rd)
  );

  sme_char_buf #(.DEPTH(PAT_MAX), .AW(5)) u_pat_buf (
    .clk     (clk),
    .we_i    (bus.wr_en && !busy_q && bus.wr_sel),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (pat_raddr),
    .rdata_o (pat_rd)
  );

  // State and registered outputs; buffers are deliberately outside this reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      slen_q        <= '0;
      plen_q        <= '0;
      wcnt_q        <= '0;
      busy_q        <= 1'b0;
      chardata_q    <= '0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slen_q        <= slen_d;
      plen_q        <= plen_d;
      wcnt_q        <= wcnt_d;
      busy_q        <= busy_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
      res_valid_q   <= res_valid_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // Next state; the char for the coming cycle is loaded one edge ahead so the
  // string-to-pattern handover has no idle cycle between them.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slen_d        = slen_q;
    plen_d        = plen_q;
    wcnt_d        = wcnt_q;
    busy_d        = busy_q;
    chardata_d    = '0;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    res_valid_d   = res_valid_q;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && lens_ok(bus.str_len, bus.pat_len, STR_MAX, PAT_MAX)) begin
          busy_d = 1'b1;
          slen_d = bus.str_len;
          plen_d = bus.pat_len;
          idx_d  = 6'd1;
          if (bus.str_len != 6'd0) begin
            state_d    = ST_SEND_STR;
            isstring_d = 1'b1;
            chardata_d = str_rd;
          end else begin
            state_d     = ST_SEND_PAT;
            ispattern_d = 1'b1;
            chardata_d  = pat_rd;
          end
        end
      end
      ST_SEND_STR: begin
        if (idx_q == slen_q) begin
          state_d     = ST_SEND_PAT;
          ispattern_d = 1'b1;
          chardata_d  = pat_rd;
          idx_d       = 6'd1;
        end else begin
          isstring_d = 1'b1;
          chardata_d = str_rd;
          idx_d      = idx_q + 6'd1;
        end
      end
      ST_SEND_PAT: begin
        if (idx_q == {2'b00, plen_q}) begin
          state_d = ST_WAIT;
          wcnt_d  = '0;
        end else begin
          ispattern_d = 1'b1;
          chardata_d  = pat_rd;
          idx_d       = idx_q + 6'd1;
        end
      end
      ST_WAIT: begin
        if (bus.valid) begin
          state_d       = ST_RESULT;
          res_valid_d   = 1'b1;
          res_match_d   = bus.match;
          res_index_d   = bus.match_index;
          res_timeout_d = 1'b0;
        end else if (wcnt_q == 8'(TIMEOUT - 1)) begin
          state_d       = ST_RESULT;
          res_valid_d   = 1'b1;
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      ST_RESULT: begin
        if (bus.res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.chardata    = chardata_q;
  assign bus.isstring    = isstring_q;
  assign bus.ispattern   = ispattern_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_match   = res_match_q;
  assign bus.res_index   = res_index_q;
  assign bus.res_timeout = res_timeout_q;

endmodule

// File: doc/sme_feeder.md
# sme_feeder

Host-side driver for the string-matching engine's serial load interface. Holds one target string (up to 32 chars) and one pattern (up to 8 chars) in local buffers written by a host port. On `start` it streams them out on `chardata`/`isstring`/`ispattern`, then waits for the engine's `valid` pulse and returns `match`/`match_index` to the host through a valid/ready result port. Sits between the testbench/host controller and the matcher and is the transmitting end of that protocol.

## Interface
- `STR_MAX`, 32, string buffer depth in chars.
- `PAT_MAX`, 8, pattern buffer depth in chars.
- `TIMEOUT`, 255, maximum WAIT cycles before giving up (1..255).
- `clk` in 1: the single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: buffer write strobe.
- `wr_sel` in 1: 0 = string buffer, 1 = pattern buffer.
- `wr_addr` in 5: char index.
- `wr_data` in 8: ASCII char.
- `str_len` in 6: string length for this run; 0 = skip string phase (engine reuses previous string).
- `pat_len` in 4: pattern length, legal 1..PAT_MAX.
- `start` in 1: begin a run (sampled in IDLE only).
- `busy` out 1: high from accepted start until result consumed.
- `chardata` out 8, `isstring` out 1, `ispattern` out 1: to engine.
- `valid` in 1, `match` in 1, `match_index` in 5: from engine.
- `res_valid` out 1, `res_match` out 1, `res_index` out 5, `res_timeout` out 1: result to host.
- `res_ready` in 1: host accepts result.

## Operation
- States: IDLE, SEND_STR, SEND_PAT, WAIT, RESULT.
- IDLE: `start` accepted iff 1 ≤ `pat_len` ≤ PAT_MAX and `str_len` ≤ STR_MAX; else ignored. Lengths latched. Next: SEND_STR if `str_len`≠0, else SEND_PAT. Index counter cleared.
- SEND_STR: drive `isstring`=1, `chardata`=str_buf[idx], idx++ each cycle; after `str_len` chars go SEND_PAT with no gap cycle (a gap would make the engine start matching early).
- SEND_PAT: `ispattern`=1, `chardata`=pat_buf[idx] for `pat_len` cycles, then WAIT.
- WAIT: strobes low, `chardata`=0; 8-bit counter increments per cycle. On `valid`: capture `match`, `match_index`, `res_timeout`=0 → RESULT. If counter reaches TIMEOUT with no `valid`: `res_match`=0, `res_index`=0, `res_timeout`=1 → RESULT. `valid` and timeout in same cycle: `valid` wins.
- RESULT: `res_valid`=1, outputs stable until `res_ready`; then IDLE.
- `isstring` and `ispattern` never both high. `chardata`=0 whenever neither is high.
- Writes: accepted only when `busy`=0; `wr_addr` ≥ depth of selected buffer ignored. Buffers have no reset; contents persist across runs and across reset.
- `valid` outside WAIT ignored. `start` while `busy` ignored.

## Timing
- All outputs registered. Reset values: `busy`, `isstring`, `ispattern`, `res_valid`, `res_match`, `res_timeout` = 0; `chardata`, `res_index` = 0.
- `start` accepted at edge t → `busy`=1 and first char at t+1. String chars t+1..t+S; pattern t+S+1..t+S+P; strobes low from t+S+P+1.
- `valid` sampled at edge w → `res_valid`=1 from w+1.
- Timeout: `res_valid` with `res_timeout`=1 appears the cycle after the TIMEOUT-th WAIT cycle.
- `res_ready` with `res_valid` at edge r → `res_valid`=0, `busy`=0 after r; a new `start` is accepted at r+1 at earliest.
- `reset` mid-run: next edge returns to IDLE, strobes and all outputs to reset values; partial stream is abandoned (engine must also be reset).

## Structure
- Shared package `sme_pkg`: STR_MAX, PAT_MAX, char constants CH_CARET 8'h5E, CH_DOLLAR 8'h24, CH_DOT 8'h2E, CH_SPACE 8'h20, feeder state encoding.
- One sub-module `sme_char_buf` (parameterised depth, one write port, one combinational read port), instantiated for string and pattern.

## Test plan
- Write string "ab cd" (61 62 20 63 64), pattern "cd", start with str_len=5, pat_len=2 → isstring 5 cycles with those chars, ispattern next 2 cycles 63 64 contiguous; model returns valid, match=1, index=3 → res_valid, res_match=1, res_index=3 held until res_ready.
- Then pattern "^ab", start with str_len=0, pat_len=3 → no isstring cycles, ispattern 3 cycles 5E 61 62; result match=1, index=0.
- TIMEOUT=20, model never asserts valid → res_valid with res_timeout=1, res_match=0 one cycle after the 20th WAIT cycle.
- start with pat_len=0, then pat_len=9 → busy stays 0, no strobes.
- While busy: wr_en to pattern addr 0 and extra start → buffer unchanged, no second run; stray valid in IDLE → no res_valid.
- reset asserted during third string char → next cycle isstring=0, busy=0, res_valid=0; fresh start then streams correctly.
